ofdm_rx_frame_ctrl: RTL and testbench
=====================================

Name: ofdm_rx_frame_ctrl

Overview:
Receive-side frame timing controller for the OFDM CP-removal path. After a frame-start pulse from the sync detector, it counts valid samples per symbol (CP + body) and symbols per frame. It forwards the sample stream with one register of delay and emits per-sample markers aligned to that stream. The frame_sync pulse and valid of ofdm_remove_cp are driven from these outputs, and downstream FFT/demap stages use the symbol/sample indices.

Parameters:
DATA_SIZE, 16, width of I and Q samples
SYMBOLS_SIZE, 256, useful samples per OFDM symbol
CP_LENGHT, 8, cyclic-prefix samples per symbol
SYMBOLS_PER_FRAME, 14, OFDM symbols per frame (>=1, <=255)
START_DELAY, 0, valid samples skipped after frame start, counting the start sample itself
GAP_LENGHT, 16, valid samples after frame end during which a new start is refused

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-low reset
i_valid  in  1  input sample qualifier
in_data_i  in  DATA_SIZE  input I sample
in_data_q  in  DATA_SIZE  input Q sample
i_frame_start  in  1  frame start marker; only meaningful with i_valid=1
i_abort  in  1  drop the current frame and return to IDLE
out_valid  out  1  registered copy of i_valid
out_data_i  out  DATA_SIZE  registered in_data_i
out_data_q  out  DATA_SIZE  registered in_data_q
o_frame_sync  out  1  high with out_valid on sample 0 (first CP sample) of each symbol
o_cp_phase  out  1  high with out_valid while sample index < CP_LENGHT in RUN
o_symbol_idx  out  8  symbol index within the frame for the current output sample
o_sample_idx  out  clog2(SYMBOLS_SIZE+CP_LENGHT)  sample index within the symbol
o_frame_active  out  1  output sample belongs to a frame (RUN)
o_frame_done  out  1  one-cycle pulse with the last sample of the last symbol
o_start_err  out  1  one-cycle pulse when i_frame_start is refused

Behaviour:
- SYM_LEN = SYMBOLS_SIZE+CP_LENGHT. Counters advance only on i_valid=1 cycles.
- Latency: an input sample accepted at cycle t appears at t+1 on out_* together with its markers.
- When i_valid=0: next cycle has out_valid=0, o_frame_sync=0, o_frame_done=0, o_start_err=0, and o_cp_phase=0. Indices and o_frame_active hold. Data is don't-care but holds.
- Reset (i_reset=0 at an edge): FSM goes to IDLE and counters clear. All outputs are 0 on the next cycle, including data. Reset takes effect mid-frame with no o_frame_done.
- States:
  - IDLE: on i_valid & i_frame_start, go to DELAY if START_DELAY>0. Otherwise go to RUN, and this sample is sample 0 of symbol 0.
  - DELAY: START_DELAY valid samples, including the start sample, are not part of the frame. The next valid sample enters RUN as sample 0.
  - RUN: sample_idx runs 0..SYM_LEN-1. At the wrap, symbol_idx increments. On sample SYM_LEN-1 of symbol SYMBOLS_PER_FRAME-1, o_frame_done pulses, then the FSM goes to GAP, or to IDLE if GAP_LENGHT=0.
  - GAP: counts GAP_LENGHT valid samples, then goes to IDLE. o_frame_active=0 in GAP.
- Markers in RUN:
  - o_frame_active=1.
  - o_frame_sync=1 when sample_idx=0.
  - o_cp_phase=1 when sample_idx<CP_LENGHT.
- Refused starts: i_valid & i_frame_start in DELAY, RUN or GAP is ignored and o_start_err pulses with that sample. This includes a start on the frame's last sample.
- i_abort in any state sends the FSM to IDLE for the next sample, with no o_frame_done. The abort sample itself is output with frame_active=0.
- If i_abort and i_frame_start are high together, abort wins: the start is ignored and no error is raised.
- Indices reset to 0 when entering IDLE.

Test Plan:
Bench parameters unless noted: SYMBOLS_SIZE=16, CP_LENGHT=4, SYMBOLS_PER_FRAME=3, START_DELAY=2, GAP_LENGHT=5. Sample numbers below count valid input samples.
1. Continuous valid, start on sample 10 -> o_frame_sync on output samples 12, 32, 52; o_cp_phase on 12-15, 32-35, 52-55; o_frame_active on 12-71; o_frame_done on 71 only; o_symbol_idx=2 on 52-71.
2. i_valid alternating 1/0, same start -> identical markers on valid samples only; every out_valid=0 cycle has o_frame_sync=0; data matches input delayed by one cycle.
3. Starts on samples 40 and 74 -> o_start_err on both, and the frame of test 1 is unchanged. Start on sample 77 -> accepted, with o_frame_sync on 79.
4. i_abort on sample 30 -> o_frame_active=0 from 30, no o_frame_done. Start on 31 -> accepted, with sync on 33. Abort and start together -> no start, no error.
5. i_reset low for one cycle during RUN -> all outputs 0 next cycle; a following start behaves as in test 1.
6. Default parameters with continuous valid, start at 0 -> sync every 264 samples, 14 syncs, frame_done on sample 3695.

Source files
------------

// File: rtl/ofdm_rx_frame_ctrl.sv
// Receive-side OFDM frame timing controller for the CP-removal path.
// After an accepted frame start it counts valid samples per symbol (CP + body)
// and symbols per frame, forwarding the sample stream with one register of
// delay and emitting per-sample markers aligned to that delayed stream.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-low reset
//   i_valid, in_data_i, in_data_q  input sample stream
//   i_frame_start, i_abort         frame start marker / drop current frame
//   out_valid, out_data_i/q        input stream delayed by one cycle
//   o_frame_sync, o_cp_phase       symbol start / cyclic-prefix markers
//   o_symbol_idx, o_sample_idx     position of the output sample in the frame
//   o_frame_active                 output sample belongs to a frame
//   o_frame_done, o_start_err      last frame sample / refused start pulses
module ofdm_rx_frame_ctrl #(
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned SYMBOLS_SIZE      = 256,
  parameter int unsigned CP_LENGHT         = 8,
  parameter int unsigned SYMBOLS_PER_FRAME = 14,
  parameter int unsigned START_DELAY       = 0,
  parameter int unsigned GAP_LENGHT        = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_valid,
  input  logic [DATA_SIZE-1:0]                      in_data_i,
  input  logic [DATA_SIZE-1:0]                      in_data_q,
  input  logic                                      i_frame_start,
  input  logic                                      i_abort,
  output logic                                      out_valid,
  output logic [DATA_SIZE-1:0]                      out_data_i,
  output logic [DATA_SIZE-1:0]                      out_data_q,
  output logic                                      o_frame_sync,
  output logic                                      o_cp_phase,
  output logic [7:0]                                o_symbol_idx,
  output logic [$clog2(SYMBOLS_SIZE+CP_LENGHT)-1:0] o_sample_idx,
  output logic                                      o_frame_active,
  output logic                                      o_frame_done,
  output logic                                      o_start_err
);

  localparam int unsigned SYM_LEN = SYMBOLS_SIZE + CP_LENGHT;
  localparam int unsigned SIDX_W  = $clog2(SYMBOLS_SIZE + CP_LENGHT);
  localparam int unsigned DCNT_W  = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int unsigned GCNT_W  = (GAP_LENGHT > 0) ? $clog2(GAP_LENGHT + 1) : 1;
  // One extra bit so CP_LENGHT == SYM_LEN still compares correctly.
  localparam logic [SIDX_W:0]       CP_L     = (SIDX_W + 1)'(CP_LENGHT);
  localparam logic [SIDX_W-1:0]     SIDX_MAX = SIDX_W'(SYM_LEN - 1);
  localparam logic [7:0]            SYM_MAX  = 8'(SYMBOLS_PER_FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_GAP} state_t;

  state_t              state, state_nxt;
  logic [SIDX_W-1:0]   sidx, sidx_nxt;
  logic [7:0]          sym, sym_nxt;
  logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
  logic [GCNT_W-1:0]   gcnt, gcnt_nxt;

  // Classification of the sample presented this cycle.
  logic                in_frame_c;
  logic [SIDX_W-1:0]   cur_sidx_c;
  logic [7:0]          cur_sym_c;
  logic                last_c;
  logic                start_err_c;

  // Next-state and per-sample classification.
  always_comb begin
    state_nxt   = state;
    sidx_nxt    = sidx;
    sym_nxt     = sym;
    dcnt_nxt    = dcnt;
    gcnt_nxt    = gcnt;
    in_frame_c  = 1'b0;
    cur_sidx_c  = sidx;
    cur_sym_c   = sym;
    last_c      = 1'b0;
    start_err_c = 1'b0;

    if (i_abort) begin
      state_nxt = S_IDLE;
      sidx_nxt  = '0;
      sym_nxt   = '0;
      dcnt_nxt  = '0;
      gcnt_nxt  = '0;
    end else if (i_valid) begin
      case (state)
        S_IDLE: begin
          if (i_frame_start) begin
            if (START_DELAY > 0) begin
              state_nxt = S_DELAY;
              dcnt_nxt  = DCNT_W'(1);
            end else begin
              in_frame_c = 1'b1;
              cur_sidx_c = '0;
              cur_sym_c  = '0;
            end
          end
        end
        S_DELAY: begin
          start_err_c = i_frame_start;
          // Start sample already counted; sample after the last skipped one is sample 0.
          if (dcnt >= DCNT_W'(START_DELAY)) begin
            in_frame_c = 1'b1;
            cur_sidx_c = '0;
            cur_sym_c  = '0;
          end else begin
            dcnt_nxt = dcnt + DCNT_W'(1);
          end
        end
        S_RUN: begin
          start_err_c = i_frame_start;
          in_frame_c  = 1'b1;
        end
        S_GAP: begin
          start_err_c = i_frame_start;
          if (gcnt == GCNT_W'(GAP_LENGHT - 1)) begin
            state_nxt = S_IDLE;
            gcnt_nxt  = '0;
          end else begin
            gcnt_nxt = gcnt + GCNT_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase

      // Advance the symbol/sample counters for a frame sample.
      if (in_frame_c) begin
        last_c = (cur_sidx_c == SIDX_MAX) && (cur_sym_c == SYM_MAX);
        if (last_c) begin
          state_nxt = (GAP_LENGHT > 0) ? S_GAP : S_IDLE;
          sidx_nxt  = '0;
          sym_nxt   = '0;
          dcnt_nxt  = '0;
          gcnt_nxt  = '0;
        end else if (cur_sidx_c == SIDX_MAX) begin
          state_nxt = S_RUN;
          sidx_nxt  = '0;
          sym_nxt   = cur_sym_c + 8'd1;
        end else begin
          state_nxt = S_RUN;
          sidx_nxt  = cur_sidx_c + SIDX_W'(1);
          sym_nxt   = cur_sym_c;
        end
      end
    end
  end

  // State, counters and the registered output stage.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state          <= S_IDLE;
      sidx           <= '0;
      sym            <= '0;
      dcnt           <= '0;
      gcnt           <= '0;
      out_valid      <= 1'b0;
      out_data_i     <= '0;
      out_data_q     <= '0;
      o_frame_sync   <= 1'b0;
      o_cp_phase     <= 1'b0;
      o_symbol_idx   <= '0;
      o_sample_idx   <= '0;
      o_frame_active <= 1'b0;
      o_frame_done   <= 1'b0;
      o_start_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      sidx         <= sidx_nxt;
      sym          <= sym_nxt;
      dcnt         <= dcnt_nxt;
      gcnt         <= gcnt_nxt;
      out_valid    <= i_valid;
      o_frame_sync <= in_frame_c && (cur_sidx_c == '0);
      o_cp_phase   <= in_frame_c && ({1'b0, cur_sidx_c} < CP_L);
      o_frame_done <= last_c;
      o_start_err  <= start_err_c;
      if (i_valid) begin
        out_data_i <= in_data_i;
        out_data_q <= in_data_q;
      end
      // Indices and frame_active hold across invalid cycles unless aborted.
      if (i_abort) begin
        o_frame_active <= 1'b0;
        o_symbol_idx   <= '0;
        o_sample_idx   <= '0;
      end else if (i_valid) begin
        o_frame_active <= in_frame_c;
        o_symbol_idx   <= in_frame_c ? cur_sym_c : 8'd0;
        o_sample_idx   <= in_frame_c ? cur_sidx_c : '0;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_rx_frame_ctrl.sv
// Bench for ofdm_rx_frame_ctrl: small-parameter instance checked cycle by cycle
// against a frame-window reference model, plus a default-parameter instance.
module tb_ofdm_rx_frame_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned SS    = 16;
  localparam int unsigned CP    = 4;
  localparam int unsigned SPF   = 3;
  localparam int unsigned SD    = 2;
  localparam int unsigned GL    = 5;
  localparam int          SYM   = SS + CP;
  localparam int          FRAME = SPF * SYM;
  localparam int unsigned SIW   = $clog2(SS + CP);
  localparam int unsigned OW    = 6 + 8 + SIW + 2 * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small-parameter DUT
  logic          valid, fstart, abort;
  logic [DW-1:0] di, dq;
  logic          out_valid, o_frame_sync, o_cp_phase, o_frame_active, o_frame_done, o_start_err;
  logic [DW-1:0] out_data_i, out_data_q;
  logic [7:0]    o_symbol_idx;
  logic [SIW-1:0] o_sample_idx;

  ofdm_rx_frame_ctrl #(
    .DATA_SIZE(DW), .SYMBOLS_SIZE(SS), .CP_LENGHT(CP), .SYMBOLS_PER_FRAME(SPF),
    .START_DELAY(SD), .GAP_LENGHT(GL)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .in_data_i(di), .in_data_q(dq),
    .i_frame_start(fstart), .i_abort(abort), .out_valid(out_valid),
    .out_data_i(out_data_i), .out_data_q(out_data_q), .o_frame_sync(o_frame_sync),
    .o_cp_phase(o_cp_phase), .o_symbol_idx(o_symbol_idx), .o_sample_idx(o_sample_idx),
    .o_frame_active(o_frame_active), .o_frame_done(o_frame_done), .o_start_err(o_start_err)
  );

  // Default-parameter DUT
  logic          v2, s2, a2;
  logic [15:0]   d2i, d2q;
  logic          ov2, sync2, cp2, act2, done2, err2;
  logic [15:0]   od2i, od2q;
  logic [7:0]    sym2;
  logic [8:0]    sidx2;

  ofdm_rx_frame_ctrl dut_def (
    .i_clk(clk), .i_reset(rst_n), .i_valid(v2), .in_data_i(d2i), .in_data_q(d2q),
    .i_frame_start(s2), .i_abort(a2), .out_valid(ov2), .out_data_i(od2i), .out_data_q(od2q),
    .o_frame_sync(sync2), .o_cp_phase(cp2), .o_symbol_idx(sym2), .o_sample_idx(sidx2),
    .o_frame_active(act2), .o_frame_done(done2), .o_start_err(err2)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: frames described as absolute valid-sample windows.
  int m_k, m_first, m_busy_end;
  logic          e_valid, e_sync, e_cp, e_active, e_done, e_err;
  logic [7:0]    e_sym;
  logic [SIW-1:0] e_sidx;
  logic [DW-1:0] e_di, e_dq;

  task automatic model_reset();
    m_first = -1; m_busy_end = -1;
    {e_valid, e_sync, e_cp, e_active, e_done, e_err} = '0;
    e_sym = '0; e_sidx = '0; e_di = '0; e_dq = '0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic a,
                            input logic [DW-1:0] xi, input logic [DW-1:0] xq);
    int off;
    e_valid = v; e_sync = 1'b0; e_cp = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (v) begin e_di = xi; e_dq = xq; end
    if (a) begin
      m_first = -1; m_busy_end = -1;
      e_active = 1'b0; e_sym = '0; e_sidx = '0;
      if (v) m_k++;
      return;
    end
    if (!v) return;
    if (s) begin
      if (m_k > m_busy_end) begin
        m_first    = m_k + SD;
        m_busy_end = m_first + FRAME - 1 + GL;
      end else begin
        e_err = 1'b1;
      end
    end
    if (m_first >= 0 && m_k >= m_first && m_k < m_first + FRAME) begin
      off      = m_k - m_first;
      e_active = 1'b1;
      e_sync   = (off % SYM) == 0;
      e_cp     = (off % SYM) < CP;
      e_done   = off == FRAME - 1;
      e_sym    = 8'(off / SYM);
      e_sidx   = SIW'(off % SYM);
    end else begin
      e_active = 1'b0; e_sym = '0; e_sidx = '0;
    end
    m_k++;
  endtask

  // Apply one cycle of stimulus to the small DUT and advance the model.
  task automatic drive(input logic v, input logic s, input logic a);
    logic [DW-1:0] xi, xq;
    xi = DW'($urandom); xq = DW'($urandom);
    valid = v; fstart = s; abort = a; di = xi; dq = xq;
    model_step(v, s, a, xi, xq);
    @(posedge clk); #1;
  endtask

  function automatic logic [OW-1:0] obs();
    return {out_valid, o_frame_sync, o_cp_phase, o_frame_active, o_frame_done, o_start_err,
            o_symbol_idx, o_sample_idx, out_data_i, out_data_q};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {e_valid, e_sync, e_cp, e_active, e_done, e_err, e_sym, e_sidx, e_di, e_dq};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; fstart = 1'b1; abort = 1'b0; di = 16'hA5A5; dq = 16'h5A5A;
    v2 = 1'b0; s2 = 1'b0; a2 = 1'b0; d2i = '0; d2q = '0;
    m_k = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++;
    if (obs() !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", obs());
    end
    model_reset();
    valid = 1'b0; fstart = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    int sync_q[$];
    int done_q[$];
    int sym2_cnt = 0;
    for (int k = 0; k < 90; k++) begin
      drive(1'b1, k == 10, 1'b0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL continuous k=%0d: got %h want %h", k, obs(), expv());
      end
      if (o_frame_sync) sync_q.push_back(k);
      if (o_frame_done) done_q.push_back(k);
      if (k >= 52 && k <= 71 && o_symbol_idx == 8'd2 && o_cp_phase == (k < 56)) sym2_cnt++;
    end
    compared++;
    if (sync_q.size() != 3 || sync_q[0] != 12 || sync_q[1] != 32 || sync_q[2] != 52) begin
      mismatched++;
      $display("FAIL continuous_sync_positions: got %p want '{12,32,52}", sync_q);
    end
    compared++;
    if (done_q.size() != 1 || done_q[0] != 71) begin
      mismatched++;
      $display("FAIL continuous_done_position: got %p want '{71}", done_q);
    end
    compared++;
    if (sym2_cnt != 20) begin
      mismatched++;
      $display("FAIL continuous_symbol2: got %0d samples want 20", sym2_cnt);
    end
  endtask

  task automatic test_alternating();
    int k = 0;
    int syncs = 0;
    int bad_idle_sync = 0;
    for (int c = 0; c < 180; c++) begin
      logic v;
      v = (c % 2) == 0;
      drive(v, v && k == 10, 1'b0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL alternating c=%0d: got %h want %h", c, obs(), expv());
      end
      if (out_valid && o_frame_sync) syncs++;
      if (!out_valid && (o_frame_sync || o_frame_done || o_cp_phase)) bad_idle_sync++;
      if (v) k++;
    end
    compared++;
    if (syncs != 3 || bad_idle_sync != 0) begin
      mismatched++;
      $display("FAIL alternating_markers: got syncs=%0d idle_markers=%0d want 3/0", syncs, bad_idle_sync);
    end
  endtask

  task automatic test_start_err();
    int errs = 0;
    int sync79 = 0;
    for (int k = 0; k < 150; k++) begin
      drive(1'b1, k == 10 || k == 40 || k == 74 || k == 77, 1'b0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL start_err k=%0d: got %h want %h", k, obs(), expv());
      end
      if (o_start_err) errs++;
      if (k == 79 && o_frame_sync) sync79 = 1;
    end
    compared++;
    if (errs != 2 || sync79 != 1) begin
      mismatched++;
      $display("FAIL start_err_summary: got errs=%0d sync79=%0d want 2/1", errs, sync79);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    int errs = 0;
    for (int k = 0; k < 70; k++) begin
      drive(1'b1, k == 10 || k == 31 || k == 50, k == 30 || k == 50);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL abort k=%0d: got %h want %h", k, obs(), expv());
      end
      if (o_frame_done) dones++;
      if (o_start_err) errs++;
      if (k == 30 || k == 50 || k == 60) begin
        compared++;
        if (o_frame_active !== 1'b0) begin
          mismatched++;
          $display("FAIL abort_inactive k=%0d: got %b want 0", k, o_frame_active);
        end
      end
      if (k == 33) begin
        compared++;
        if (o_frame_sync !== 1'b1) begin
          mismatched++;
          $display("FAIL abort_restart_sync: got %b want 1", o_frame_sync);
        end
      end
    end
    compared++;
    if (dones != 0 || errs != 0) begin
      mismatched++;
      $display("FAIL abort_pulses: got done=%0d err=%0d want 0/0", dones, errs);
    end
  endtask

  task automatic test_reset_mid();
    int sync_q[$];
    for (int k = 0; k < 20; k++) drive(1'b1, k == 5, 1'b0);
    rst_n = 1'b0; valid = 1'b1; fstart = 1'b0; abort = 1'b0; di = 16'hFFFF; dq = 16'h1234;
    @(posedge clk); #1;
    compared++;
    if (obs() !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got %h want 0", obs());
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 80; k++) begin
      drive(1'b1, k == 3, 1'b0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL reset_mid k=%0d: got %h want %h", k, obs(), expv());
      end
      if (o_frame_sync) sync_q.push_back(k);
    end
    compared++;
    if (sync_q.size() != 3 || sync_q[0] != 5 || sync_q[2] != 45) begin
      mismatched++;
      $display("FAIL reset_mid_syncs: got %p want '{5,25,45}", sync_q);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
      compared++;
      if (obs() !== expv()) begin
        mismatched++;
        $display("FAIL random c=%0d: got %h want %h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_default();
    int syncs = 0;
    int last_sync = -1;
    int done_at = -1;
    int dones = 0;
    valid = 1'b0; fstart = 1'b0; abort = 1'b0;
    for (int n = 0; n < 3720; n++) begin
      v2 = 1'b1; s2 = n == 0; a2 = 1'b0; d2i = 16'(n); d2q = 16'(~n);
      @(posedge clk); #1;
      if (sync2) begin
        if (last_sync >= 0) begin
          compared++;
          if (n - last_sync != 264) begin
            mismatched++;
            $display("FAIL default_sync_spacing n=%0d: got %0d want 264", n, n - last_sync);
          end
        end
        last_sync = n;
        syncs++;
      end
      if (done2) begin
        dones++;
        done_at = n;
        compared++;
        if (sym2 !== 8'd13 || sidx2 !== 9'd263) begin
          mismatched++;
          $display("FAIL default_done_idx: got sym=%0d sidx=%0d want 13/263", sym2, sidx2);
        end
      end
    end
    v2 = 1'b0; s2 = 1'b0;
    compared++;
    if (syncs != 14 || last_sync != 3432) begin
      mismatched++;
      $display("FAIL default_syncs: got %0d last=%0d want 14/3432", syncs, last_sync);
    end
    compared++;
    if (dones != 1 || done_at != 3695) begin
      mismatched++;
      $display("FAIL default_done: got count=%0d at=%0d want 1/3695", dones, done_at);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_alternating();
    test_start_err();
    test_abort();
    test_reset_mid();
    test_random();
    test_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
